// File: rtl/id_ex_ctrl_pipe_if.sv
// id_ex_ctrl_pipe_if: decode-side and execute-side handshake bundle for the ID/EX boundary.
interface id_ex_ctrl_pipe_if #(
  parameter int EXEC_CMD_W = 4,
  parameter int DATA_W     = 32,
  parameter int REG_W      = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [EXEC_CMD_W-1:0] in_cmd;
  logic [5:0]            in_ctrl;
  logic [DATA_W-1:0]     in_pc;
  logic [DATA_W-1:0]     in_rn;
  logic [DATA_W-1:0]     in_rm;
  logic [REG_W-1:0]      in_dest;
  logic [3:0]            in_cond;
  logic [3:0]            status;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [EXEC_CMD_W-1:0] out_cmd;
  logic [5:0]            out_ctrl;
  logic [DATA_W-1:0]     out_pc;
  logic [DATA_W-1:0]     out_rn;
  logic [DATA_W-1:0]     out_rm;
  logic [REG_W-1:0]      out_dest;
  modport master (
    output in_valid, in_cmd, in_ctrl, in_pc, in_rn, in_rm, in_dest, in_cond, status, flush, out_ready,
    input  in_ready, out_valid, out_cmd, out_ctrl, out_pc, out_rn, out_rm, out_dest
  );
  modport slave (
    input  in_valid, in_cmd, in_ctrl, in_pc, in_rn, in_rm, in_dest, in_cond, status, flush, out_ready,
    output in_ready, out_valid, out_cmd, out_ctrl, out_pc, out_rn, out_rm, out_dest
  );
endinterface

// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: 2-entry skid buffer between decode and execute with flush.
// Define ID_EX_COND_SQUASH_EN to zero ctrl of bundles whose condition fails at accept.
module id_ex_ctrl_pipe #(
  parameter int EXEC_CMD_W = 4,
  parameter int DATA_W     = 32,
  parameter int REG_W      = 4
) (
  input logic clk,
  input logic rst,
  id_ex_ctrl_pipe_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [EXEC_CMD_W-1:0] cmd;
    logic [5:0]            ctrl;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     rn;
    logic [DATA_W-1:0]     rm;
    logic [REG_W-1:0]      dest;
  } bundle_t;
  state_t  r_state, w_next;
  bundle_t r_main, r_skid, w_in;
  logic    r_in_ready, w_acc, w_emt, w_out_valid, w_cond_ok;
`ifdef ID_EX_COND_SQUASH_EN
  logic w_n, w_z, w_c, w_v, w_base;
  assign {w_n, w_z, w_c, w_v} = bus.status;
  // odd codes are the negation of the preceding even code; 111x always passes
  always_comb begin
    case (bus.in_cond[3:1])
      3'd0:    w_base = w_z;
      3'd1:    w_base = w_c;
      3'd2:    w_base = w_n;
      3'd3:    w_base = w_v;
      3'd4:    w_base = w_c & !w_z;
      3'd5:    w_base = w_n == w_v;
      3'd6:    w_base = !w_z & (w_n == w_v);
      default: w_base = 1'b1;
    endcase
    w_cond_ok = (bus.in_cond[3:1] == 3'd7) | (w_base ^ bus.in_cond[0]);
  end
`else
  assign w_cond_ok = 1'b1;
`endif
  assign w_in        = {bus.in_cmd, w_cond_ok ? bus.in_ctrl : 6'd0, bus.in_pc, bus.in_rn, bus.in_rm, bus.in_dest};
  assign w_out_valid = r_state != EMPTY;
  assign w_acc       = bus.in_valid & r_in_ready;
  assign w_emt       = w_out_valid & bus.out_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   w_next = w_acc ? ONE : EMPTY;
      ONE:     w_next = (w_acc & !w_emt) ? TWO : (!w_acc & w_emt) ? EMPTY : ONE;
      default: w_next = w_emt ? ONE : TWO;
    endcase
  end
  // flush wins over accept/emit; only valid state and ctrl need clearing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (bus.flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main.ctrl <= '0;
      r_skid.ctrl <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_next != TWO;
      if (r_state == TWO ? w_emt : (w_acc & ((r_state == EMPTY) | w_emt)))
        r_main <= (r_state == TWO) ? r_skid : w_in;
      if ((r_state == ONE) & w_acc & !w_emt)
        r_skid <= w_in;
    end
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_cmd   = r_main.cmd;
  assign bus.out_ctrl  = w_out_valid ? r_main.ctrl : 6'd0;
  assign bus.out_pc    = r_main.pc;
  assign bus.out_rn    = r_main.rn;
  assign bus.out_rm    = r_main.rm;
  assign bus.out_dest  = r_main.dest;
endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// tb_id_ex_ctrl_pipe: scoreboard bench for the ID/EX skid buffer.
module tb_id_ex_ctrl_pipe;
  typedef struct packed {
    logic [3:0]  cmd;
    logic [5:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  dest;
  } bun_t;
`ifdef ID_EX_COND_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bun_t q[$];
  id_ex_ctrl_pipe_if bus ();
  id_ex_ctrl_pipe dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic bun_t mk(input logic [3:0] c, input logic [5:0] k, input logic [31:0] p, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] d);
    return {c, k, p, a, b, d};
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, a, e);
    end
  endtask
  task automatic drive(input bun_t b, input logic [3:0] cond, input logic [3:0] st);
    bus.in_cmd   = b.cmd;
    bus.in_ctrl  = b.ctrl;
    bus.in_pc    = b.pc;
    bus.in_rn    = b.rn;
    bus.in_rm    = b.rm;
    bus.in_dest  = b.dest;
    bus.in_cond  = cond;
    bus.status   = st;
    bus.in_valid = 1'b1;
  endtask
  // present b until accepted; expected ctrl is zero only when the condition fails and squashing is built in
  task automatic send(input bun_t b, input logic [3:0] cond, input logic [3:0] st, input bit fails);
    int   n = 0;
    bun_t e = b;
    drive(b, cond, st);
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 required 1 within 20 cycles");
    end else begin
      if (fails && SQ) e.ctrl = '0;
      q.push_back(e);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain(input string n);
    int k = 0;
    while (q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(n, 128'(q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask
  logic [3:0] cv[9] = '{4'b0001, 4'b0000, 4'b1010, 4'b1011, 4'b1000, 4'b1001, 4'b1111, 4'b1100, 4'b1101};
  logic [3:0] sv[9] = '{4'b0100, 4'b0100, 4'b1001, 4'b1001, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0100};
  bit         fv[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_cmd    = '0;
    bus.in_ctrl   = '0;
    bus.in_pc     = '0;
    bus.in_rn     = '0;
    bus.in_rm     = '0;
    bus.in_dest   = '0;
    bus.in_cond   = '0;
    bus.status    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rst && bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_emit: got pc=%h cmd=%h required no output", bus.out_pc, bus.out_cmd);
          end else
            chk("emit", 128'({bus.out_cmd, bus.out_ctrl, bus.out_pc, bus.out_rn, bus.out_rm, bus.out_dest}),
                128'(q.pop_front()));
        end
        if (rst && !bus.out_valid) chk("bubble_ctrl", 128'(bus.out_ctrl), 128'(0));
      end
      begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1);
      end
    join_none
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("rst_cmd", 128'(bus.out_cmd), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    #2 rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 128'(bus.in_ready), 128'(1));
    chk("release_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(mk(4'b0010, 6'b001000, 32'h100, 32'd5, 32'd7, 4'd3), 4'b1110, 4'b0000, 1'b0);
    @(negedge clk);
    chk("latency_valid", 128'(bus.out_valid), 128'(1));
    @(negedge clk);
    chk("single_bubble", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(mk(4'hA, 6'b100100, 32'h200, 32'h11, 32'h12, 4'd1), 4'b1110, 4'b0000, 1'b0);
    send(mk(4'hB, 6'b010100, 32'h204, 32'h21, 32'h22, 4'd2), 4'b1110, 4'b0000, 1'b0);
    fork
      send(mk(4'hC, 6'b000110, 32'h208, 32'h31, 32'h32, 4'd4), 4'b1110, 4'b0000, 1'b0);
      begin
        @(negedge clk);
        chk("in_ready_full", 128'(bus.in_ready), 128'(0));
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    bus.out_ready = 1'b0;
    send(mk(4'h5, 6'b111111, 32'h300, 32'h41, 32'h42, 4'd5), 4'b1110, 4'b0000, 1'b0);
    send(mk(4'h6, 6'b101010, 32'h304, 32'h51, 32'h52, 4'd6), 4'b1110, 4'b0000, 1'b0);
    drive(mk(4'h7, 6'b010101, 32'h308, 32'h61, 32'h62, 4'd7), 4'b1110, 4'b0000);
    bus.flush = 1'b1;
    q.delete();
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("flush_idle", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(mk(4'h9, 6'b001111, 32'hDEAD, 32'hBEEF, 32'h1234, 4'd9), 4'b1110, 4'b0000, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 128'(bus.out_valid), 128'(0));
    chk("arst_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("arst_pc", 128'(bus.out_pc), 128'(0));
    chk("arst_rn", 128'(bus.out_rn), 128'(0));
    chk("arst_cmd", 128'(bus.out_cmd), 128'(0));
    chk("arst_in_ready", 128'(bus.in_ready), 128'(0));
    q.delete();
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("arst_recover", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++)
      send(mk(4'(i), (i == 7) ? 6'b111111 : 6'b001001, 32'h400 + 32'(i), 32'(i), 32'(i + 1), 4'(i)), cv[i], sv[i], fv[i]);
    drain("cond_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
